// File: rtl/fcmp_pipe.sv
// Two-stage pipelined IEEE-754 comparator (FEQ/FLT/FLE) with valid/ready flow
// control, tag passthrough and invalid-operation flag.
module fcmp_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int TAG_W = 5,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [1:0]               in_op,
  input  logic [EXP_W+MAN_W:0]     in_x1,
  input  logic [EXP_W+MAN_W:0]     in_x2,
  input  logic [TAG_W-1:0]         in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_y,
  output logic                     out_nv,
  output logic [TAG_W-1:0]         out_tag
);

  localparam int W   = 1 + EXP_W + MAN_W;
  localparam int M_W = EXP_W + MAN_W;

  typedef enum logic [1:0] {
    OP_FEQ = 2'b00,
    OP_FLT = 2'b01,
    OP_FLE = 2'b10,
    OP_RSV = 2'b11
  } op_e;

  function automatic logic is_nan(input logic [W-1:0] x);
    return (&x[W-2:MAN_W]) && (|x[MAN_W-1:0]);
  endfunction

  function automatic logic is_snan(input logic [W-1:0] x);
    return is_nan(x) && !x[MAN_W-1];
  endfunction

  function automatic logic is_zero(input logic [W-1:0] x);
    return ~|x[W-2:0];
  endfunction

  // Ordered less-than for non-NaN operands; both-zero handled by caller.
  function automatic logic lt_ordered(input logic s1, input logic s2,
                                      input logic [M_W-1:0] m1,
                                      input logic [M_W-1:0] m2);
    logic r;
    if (s1 != s2)
      r = s1;
    else if (!s1)
      r = (m1 < m2);
    else
      r = (m1 > m2);
    return r;
  endfunction

  logic stall;
  logic adv;
  logic acc;

  logic                 vld_p1;
  op_e                  op_p1;
  logic [TAG_W-1:0]     tag_p1;
  logic                 sgn1_p1, sgn2_p1;
  logic [M_W-1:0]       mag1_p1, mag2_p1;
  logic                 nan1_p1, nan2_p1;
  logic                 snan1_p1, snan2_p1;
  logic                 zero1_p1, zero2_p1;

  logic                 vld_p2;
  logic                 y_p2;
  logic                 nv_p2;
  logic [TAG_W-1:0]     tag_p2;

  logic                 any_nan;
  logic                 any_snan;
  logic                 both_zero;
  logic                 feq_c;
  logic                 flt_c;
  logic                 y_c;
  logic                 nv_c;

  assign stall    = vld_p2 & ~out_ready;
  assign adv      = ~stall;
  assign in_ready = adv;
  assign acc      = in_valid & in_ready;

  // ---- S1: classify operands ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
    end else if (adv) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (acc) begin
      op_p1    <= op_e'(in_op);
      tag_p1   <= in_tag;
      sgn1_p1  <= in_x1[W-1];
      sgn2_p1  <= in_x2[W-1];
      mag1_p1  <= in_x1[M_W-1:0];
      mag2_p1  <= in_x2[M_W-1:0];
      nan1_p1  <= is_nan(in_x1);
      nan2_p1  <= is_nan(in_x2);
      snan1_p1 <= is_snan(in_x1);
      snan2_p1 <= is_snan(in_x2);
      zero1_p1 <= is_zero(in_x1);
      zero2_p1 <= is_zero(in_x2);
    end
  end

  always_comb begin
    any_nan   = nan1_p1 | nan2_p1;
    any_snan  = snan1_p1 | snan2_p1;
    both_zero = zero1_p1 & zero2_p1;
    feq_c     = both_zero |
                ((sgn1_p1 == sgn2_p1) && (mag1_p1 == mag2_p1));
    flt_c     = both_zero ? 1'b0 :
                lt_ordered(sgn1_p1, sgn2_p1, mag1_p1, mag2_p1);
    y_c       = 1'b0;
    nv_c      = 1'b0;
    case (op_p1)
      OP_FEQ: begin
        y_c  = ~any_nan & feq_c;
        nv_c = any_snan;
      end
      OP_FLT: begin
        y_c  = ~any_nan & flt_c;
        nv_c = any_nan;
      end
      OP_FLE: begin
        y_c  = ~any_nan & (flt_c | feq_c);
        nv_c = any_nan;
      end
      default: begin
        y_c  = 1'b0;
        nv_c = 1'b1;
      end
    endcase
  end

  // ---- S2: registered result ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2 <= 1'b0;
      y_p2   <= 1'b0;
      nv_p2  <= 1'b0;
      tag_p2 <= '0;
    end else if (adv) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        y_p2   <= y_c;
        nv_p2  <= nv_c;
        tag_p2 <= tag_p1;
      end
    end
  end

  assign out_valid = vld_p2;
  assign out_y     = {{(XLEN-1){1'b0}}, y_p2};
  assign out_nv    = nv_p2;
  assign out_tag   = tag_p2;

endmodule

// File: tb/tb_fcmp_pipe.sv
// Directed-vector bench for fcmp_pipe: compare ops, NaN handling, backpressure
// and mid-flight reset.
module tb_fcmp_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_x1 = '0;
  logic [31:0] in_x2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_y;
  logic        out_nv;
  logic [4:0]  out_tag;

  int n_chk  = 0;
  int n_pass = 0;

  fcmp_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(5), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_nv(out_nv), .out_tag(out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, obs, exp);
  endtask

  task automatic run_op(input string nm, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tg, input logic ey, input logic env);
    int lat;
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_x1 = a; in_x2 = b; in_tag = tg;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"}, lat, 2);
    chk({nm, "_y"}, out_y, {31'b0, ey});
    chk({nm, "_nv"}, out_nv, env);
    chk({nm, "_tag"}, out_tag, tg);
  endtask

  logic [1:0]  bp_op  [4];
  logic [31:0] bp_a   [4];
  logic [31:0] bp_b   [4];
  logic        bp_y   [4];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int nxt, got, stall_left;
    logic [4:0] held_tag;
    logic [31:0] held_y;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_y", out_y, 0);
    chk("rst_out_nv", out_nv, 0);
    chk("rst_out_tag", out_tag, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    run_op("feq_one",     2'b00, 32'h3F800000, 32'h3F800000, 5'd3,  1'b1, 1'b0);
    run_op("feq_zeros",   2'b00, 32'h00000000, 32'h80000000, 5'd4,  1'b1, 1'b0);
    run_op("flt_zeros",   2'b01, 32'h00000000, 32'h80000000, 5'd5,  1'b0, 1'b0);
    run_op("fle_zeros",   2'b10, 32'h00000000, 32'h80000000, 5'd6,  1'b1, 1'b0);
    run_op("flt_neg",     2'b01, 32'hC0000000, 32'hBF800000, 5'd7,  1'b1, 1'b0);
    run_op("flt_neg_sw",  2'b01, 32'hBF800000, 32'hC0000000, 5'd8,  1'b0, 1'b0);
    run_op("flt_inf",     2'b01, 32'h7F800000, 32'h7F7FFFFF, 5'd9,  1'b0, 1'b0);
    run_op("flt_pos",     2'b01, 32'h3F800000, 32'h40000000, 5'd10, 1'b1, 1'b0);
    run_op("flt_mzero",   2'b01, 32'h80000000, 32'h3F800000, 5'd11, 1'b1, 1'b0);
    run_op("fle_negeq",   2'b10, 32'hC0000000, 32'hC0000000, 5'd12, 1'b1, 1'b0);
    run_op("feq_ulp",     2'b00, 32'h3F800000, 32'h3F800001, 5'd13, 1'b0, 1'b0);
    run_op("feq_qnan",    2'b00, 32'h7FC00000, 32'h7FC00000, 5'd14, 1'b0, 1'b0);
    run_op("feq_snan",    2'b00, 32'h7F800001, 32'h3F800000, 5'd15, 1'b0, 1'b1);
    run_op("fle_qnan",    2'b10, 32'h7FC00000, 32'h3F800000, 5'd16, 1'b0, 1'b1);
    run_op("op_rsv",      2'b11, 32'h3F800000, 32'h3F800000, 5'd17, 1'b0, 1'b1);

    // Backpressure: four back-to-back ops, consumer stalls 3 cycles.
    bp_op[0] = 2'b00; bp_a[0] = 32'h3F800000; bp_b[0] = 32'h3F800000; bp_y[0] = 1'b1;
    bp_op[1] = 2'b01; bp_a[1] = 32'h3F800000; bp_b[1] = 32'h40000000; bp_y[1] = 1'b1;
    bp_op[2] = 2'b01; bp_a[2] = 32'h40000000; bp_b[2] = 32'h3F800000; bp_y[2] = 1'b0;
    bp_op[3] = 2'b10; bp_a[3] = 32'h3F800000; bp_b[3] = 32'h3F800000; bp_y[3] = 1'b1;
    nxt = 0; got = 0; stall_left = -1; held_tag = '0; held_y = '0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      if (out_valid && stall_left < 0) stall_left = 3;
      out_ready = (stall_left > 0) ? 1'b0 : 1'b1;
      if (nxt < 4) begin
        in_valid = 1'b1; in_op = bp_op[nxt]; in_x1 = bp_a[nxt];
        in_x2 = bp_b[nxt]; in_tag = 5'(nxt + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (stall_left > 0) begin
        chk("bp_in_ready", in_ready, 0);
        if (stall_left < 3) begin
          chk("bp_hold_tag", out_tag, held_tag);
          chk("bp_hold_y", out_y, held_y);
        end
        held_tag = out_tag;
        held_y = out_y;
        stall_left--;
      end
      if (out_valid && out_ready) begin
        chk("bp_order_tag", out_tag, 5'(got + 1));
        chk("bp_y", out_y, {31'b0, bp_y[got]});
        got++;
      end
      if (in_valid && in_ready) nxt++;
    end
    in_valid = 1'b0;
    chk("bp_accepted", nxt, 4);
    chk("bp_received", got, 4);
    @(negedge clk);
    chk("bp_no_dup", out_valid, 0);

    // Reset with two ops in flight; consumer held off so nothing is consumed.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'b00; in_x1 = 32'h3F800000; in_x2 = 32'h3F800000; in_tag = 5'd20;
    @(negedge clk);
    in_tag = 5'd21;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    chk("rstmid_out_valid", out_valid, 0);
    chk("rstmid_in_ready", in_ready, 1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rstmid_no_emit", out_valid, 0);
    end
    run_op("post_rst", 2'b01, 32'hBF800000, 32'h3F800000, 5'd22, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
